// File: rtl/scroll_position_ctrl.sv
// Scroll position controller: frame-synchronous left/right scrolling of two text base positions.
// Latency: frame_pulse 1 cycle after vb rises; position/step_pulse 1 cycle after the firing frame_pulse.
// Backpressure: none, free-running; pause freezes the positions and the prescaler.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   VGA_HORZ_COORD         pixel column (not needed; boundary is purely vertical)
//   VGA_VERT_COORD         pixel row, frame boundary detected at V_ACTIVE
//   Scrolling_Sw           scroll enable (dropping it returns positions to INIT1/INIT2)
//   pause                  level, holds positions and prescaler
//   speed                  pixels moved per step, 0..7
//   dir                    (only with SCROLL_REVERSE_EN) 1 = scroll rightward
//   base_horz, base_horz2  registered lane base positions
//   step_pulse             one-cycle pulse coincident with each position update
//   frame_pulse            one-cycle pulse per frame boundary
// Optional feature macro: SCROLL_REVERSE_EN adds the dir input.
module scroll_position_ctrl #(
  parameter int          V_ACTIVE   = 480,
  parameter int          FRAME_DIV  = 2,
  parameter logic [11:0] INIT1      = 12'd640,
  parameter logic [11:0] INIT2      = 12'd3700,
  parameter logic [11:0] RELOAD     = 12'd640,
  parameter logic [11:0] WRAP_LIMIT = 12'd2999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] VGA_HORZ_COORD,
  input  logic [11:0] VGA_VERT_COORD,
  input  logic        Scrolling_Sw,
  input  logic        pause,
  input  logic [2:0]  speed,
`ifdef SCROLL_REVERSE_EN
  input  logic        dir,
`endif
  output logic [11:0] base_horz,
  output logic [11:0] base_horz2,
  output logic        step_pulse,
  output logic        frame_pulse
);

  localparam logic [11:0] V_ACT     = 12'(V_ACTIVE);
  localparam logic [3:0]  DIV_LAST  = 4'(FRAME_DIV - 1);
  // Right-hand exit point for reverse scrolling.
  localparam logic [11:0] REV_LIMIT = 12'd640;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        vb, vb_q;
  logic [3:0]  presc_q;
  logic        count_en, div_hit, step_fire, force_init, rev;
  logic        unused_horz;

  assign unused_horz = ^VGA_HORZ_COORD;

`ifdef SCROLL_REVERSE_EN
  assign rev = dir;
`else
  assign rev = 1'b0;
`endif

  // One lane update. The wrap test looks at the current value, so a lane
  // spends one step at or beyond the exit point before it reloads.
  function automatic logic [11:0] lane_next(input logic [11:0] p,
                                            input logic [2:0]  spd,
                                            input logic        right);
    logic [11:0] r;
    if (right) begin
      if ($signed(p) >= $signed(REV_LIMIT)) r = WRAP_LIMIT;
      else                                   r = p + {9'd0, spd};
    end else begin
      if ($signed(p) <= $signed(WRAP_LIMIT)) r = RELOAD;
      else                                    r = p - {9'd0, spd};
    end
    return r;
  endfunction

  // Frame boundary: rising edge of the vertical-blank flag. vb_q resets to 1
  // so powering up inside blanking does not produce a spurious pulse.
  assign vb = (VGA_VERT_COORD >= V_ACT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vb_q        <= 1'b1;
      frame_pulse <= 1'b0;
    end else begin
      vb_q        <= vb;
      frame_pulse <= vb & ~vb_q;
    end
  end

  // Scrolling_Sw=0 takes precedence over pause in every state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Scrolling_Sw) state_d = RUN;
      RUN:     if (!Scrolling_Sw) state_d = IDLE;
               else if (pause)    state_d = PAUSED;
      PAUSED:  if (!Scrolling_Sw) state_d = IDLE;
               else if (!pause)   state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // A frame arriving as pause rises still advances the prescaler (so it
  // wraps to 0 on the firing frame) but the step itself is suppressed; after
  // release a full FRAME_DIV frames pass before the next step.
  assign force_init = !Scrolling_Sw || (state_q == IDLE);
  assign count_en   = (state_q == RUN) && Scrolling_Sw && frame_pulse;
  assign div_hit    = count_en && (presc_q == DIV_LAST);
  assign step_fire  = div_hit && !pause;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      presc_q    <= 4'd0;
      base_horz  <= INIT1;
      base_horz2 <= INIT2;
      step_pulse <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_pulse <= step_fire;
      if (force_init) begin
        // Loaded on the same edge that enters IDLE, so the reset positions
        // appear the cycle after the enable drops.
        presc_q    <= 4'd0;
        base_horz  <= INIT1;
        base_horz2 <= INIT2;
      end else if (count_en) begin
        presc_q <= div_hit ? 4'd0 : presc_q + 4'd1;
        if (step_fire) begin
          base_horz  <= lane_next(base_horz,  speed, rev);
          base_horz2 <= lane_next(base_horz2, speed, rev);
        end
      end
    end
  end

endmodule

// File: tb/tb_scroll_position_ctrl.sv
// Self-checking bench for scroll_position_ctrl: directed frame sequences, hand-computed positions.
// Latency: each frame task returns after the step triggered by that frame is visible.
// Backpressure: not applicable.
module tb_scroll_position_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] VGA_HORZ_COORD;
  logic [11:0] VGA_VERT_COORD;
  logic        Scrolling_Sw;
  logic        pause;
  logic [2:0]  speed;
`ifdef SCROLL_REVERSE_EN
  logic        dir = 1'b0;
`endif
  logic [11:0] base_horz;
  logic [11:0] base_horz2;
  logic        step_pulse;
  logic        frame_pulse;

  int n_cmp = 0;
  int n_err = 0;
  int step_cnt = 0;
  int frame_cnt = 0;
  int fsave;

  always #5 clk = ~clk;

  scroll_position_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .VGA_HORZ_COORD (VGA_HORZ_COORD),
    .VGA_VERT_COORD (VGA_VERT_COORD),
    .Scrolling_Sw   (Scrolling_Sw),
    .pause          (pause),
    .speed          (speed),
`ifdef SCROLL_REVERSE_EN
    .dir            (dir),
`endif
    .base_horz      (base_horz),
    .base_horz2     (base_horz2),
    .step_pulse     (step_pulse),
    .frame_pulse    (frame_pulse)
  );

  always @(negedge clk) begin
    if (step_pulse)  step_cnt++;
    if (frame_pulse) frame_cnt++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One short frame: vb low, vb high, then the frame_pulse cycle. Optional
  // hooks raise pause or the enable during the frame_pulse cycle. Returns
  // just after the negedge following the (possible) step update.
  task automatic frame(input bit pz, input bit en);
    VGA_VERT_COORD = 12'd0;
    @(posedge clk); #1;
    VGA_VERT_COORD = 12'd480;
    @(posedge clk); #1;
    if (pz) pause = 1'b1;
    if (en) Scrolling_Sw = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); #1;
  endtask

  task automatic step2();
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n          = 1'b0;
    VGA_HORZ_COORD = 12'd0;
    VGA_VERT_COORD = 12'd500;
    Scrolling_Sw   = 1'b0;
    pause          = 1'b0;
    speed          = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_base1", base_horz, 640);
    chk("rst_base2", base_horz2, 3700);
    chk("rst_step", step_pulse, 0);
    chk("rst_frame", frame_pulse, 0);
    rst_n = 1'b1;
    // Powered up inside blanking: no boundary may be reported.
    repeat (6) @(posedge clk);
    #1;
    chk("pwrup_no_frame", frame_cnt, 0);

    // Basic stepping: speed 1, two frames per step.
    Scrolling_Sw = 1'b1;
    speed        = 3'd1;
    @(posedge clk); #1;
    frame(1'b0, 1'b0);
    chk("f1_base1", base_horz, 640);
    chk("f1_steps", step_cnt, 0);
    frame(1'b0, 1'b0);
    chk("f2_base1", base_horz, 639);
    chk("f2_base2", base_horz2, 3699);
    chk("f2_steps", step_cnt, 1);
    frame(1'b0, 1'b0);
    chk("f3_base1", base_horz, 639);
    frame(1'b0, 1'b0);
    chk("f4_base1", base_horz, 638);
    chk("f4_base2", base_horz2, 3698);
    chk("f4_steps", step_cnt, 2);
    chk("f4_frames", frame_cnt, 4);

    // Run down to 600, then drop the enable.
    speed = 3'd2;
    for (int k = 0; k < 19; k++) step2();
    chk("dn_base1", base_horz, 600);
    chk("dn_base2", base_horz2, 3660);
    chk("dn_steps", step_cnt, 21);
    Scrolling_Sw = 1'b0;
    @(posedge clk); #1;
    chk("off_base1", base_horz, 640);
    chk("off_base2", base_horz2, 3700);

    // Re-enable on a frame_pulse cycle: that frame is not counted.
    speed = 3'd0;
    frame(1'b0, 1'b1);
    chk("en_steps0", step_cnt, 21);
    frame(1'b0, 1'b0);
    chk("en_steps1", step_cnt, 21);
    frame(1'b0, 1'b0);
    chk("spd0_steps", step_cnt, 22);
    chk("spd0_base1", base_horz, 640);
    chk("spd0_base2", base_horz2, 3700);

    // Long run at speed 7: lane 2 crosses the limit, lane 1 lands on 3000.
    speed = 3'd7;
    for (int k = 1; k <= 248; k++) begin
      step2();
      if (k == 101) chk("l2_beyond", base_horz2, 2993);
      if (k == 102) chk("l2_reload", base_horz2, 640);
    end
    chk("run_base1", base_horz, 3000);
    chk("run_base2", base_horz2, 3714);
    chk("run_steps", step_cnt, 270);

    // Exact hit on the limit at speed 1.
    speed = 3'd1;
    step2();
    chk("hit_base1", base_horz, 2999);
    chk("hit_base2", base_horz2, 3713);
    step2();
    chk("wrap_base1", base_horz, 640);
    chk("wrap_base2", base_horz2, 3712);

    // Overshoot past the limit at speed 7 from 3003.
    speed = 3'd7;
    for (int k = 0; k < 247; k++) step2();
    speed = 3'd4;
    step2();
    chk("pre_base1", base_horz, 3003);
    chk("pre_base2", base_horz2, 3724);
    speed = 3'd7;
    step2();
    chk("over_base1", base_horz, 2996);
    chk("over_base2", base_horz2, 3717);
    step2();
    chk("ovwrap_base1", base_horz, 640);
    chk("ovwrap_base2", base_horz2, 3710);
    chk("ov_steps", step_cnt, 522);

    // Pause rising together with the firing frame_pulse.
    frame(1'b0, 1'b0);
    frame(1'b1, 1'b0);
    chk("pz_steps", step_cnt, 522);
    chk("pz_base1", base_horz, 640);
    for (int k = 0; k < 5; k++) frame(1'b0, 1'b0);
    chk("pzh_steps", step_cnt, 522);
    chk("pzh_base1", base_horz, 640);
    chk("pzh_base2", base_horz2, 3710);
    pause = 1'b0;
    @(posedge clk); #1;
    frame(1'b0, 1'b0);
    chk("rel_steps1", step_cnt, 522);
    frame(1'b0, 1'b0);
    chk("rel_steps2", step_cnt, 523);
    chk("rel_base1", base_horz, 633);
    chk("rel_base2", base_horz2, 3703);

    // Reset mid-frame inside blanking.
    VGA_VERT_COORD = 12'd500;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mrst_base1", base_horz, 640);
    chk("mrst_base2", base_horz2, 3700);
    chk("mrst_step", step_pulse, 0);
    chk("mrst_frame", frame_pulse, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    fsave = frame_cnt;
    repeat (5) @(posedge clk);
    #1;
    VGA_VERT_COORD = 12'd480;
    repeat (3) @(posedge clk);
    #1;
    chk("mrst_no_frame", frame_cnt, fsave);
    frame(1'b0, 1'b0);
    chk("mrst_frame_back", frame_cnt, fsave + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
